// File: rtl/dlx_mem_arbiter.sv
// Unified-memory sequencer for the DLX: arbitrates fetch, data and debug ports
// onto one fixed-latency memory and returns per-port data and acknowledges.
module dlx_mem_arbiter #(
   parameter int unsigned AW       = 32,
   parameter int unsigned DW       = 32,
   parameter int unsigned MEM_LAT  = 2,
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic [DW-1:0] if_rdata,
   output logic          if_rvalid,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic [DW-1:0] d_rdata,
   output logic          d_rvalid,
   input  logic          dbg_req,
   input  logic          dbg_we,
   input  logic [AW-1:0] dbg_addr,
   input  logic [DW-1:0] dbg_wdata,
   output logic [DW-1:0] dbg_rdata,
   output logic          dbg_rvalid,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          pipe_stall,
   output logic          busy
);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_e;
   typedef enum logic [1:0] {P_NONE, P_IF, P_D, P_DBG} port_e;

   localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);
   localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

   state_e        state_q, state_d;
   port_e         win_q, win_d, grant;
   logic          we_q, we_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [3:0]    lat_q, lat_d, wait_q, wait_d;

   logic          mem_en_q, mem_en_d, mem_we_q, mem_we_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [DW-1:0] mem_wdata_q, mem_wdata_d;
   logic [DW-1:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d, dbg_rdata_q, dbg_rdata_d;
   logic          if_rvalid_q, if_rvalid_d, d_rvalid_q, d_rvalid_d, dbg_rvalid_q, dbg_rvalid_d;
   logic          busy_q, busy_d;

   logic          arb_en, elig_if, elig_d, elig_dbg, forced, capture;

   // The port acknowledged in RESP is excluded so it cannot re-win on its held request.
   always_comb begin
      arb_en   = (state_q == S_IDLE) || (state_q == S_RESP);
      elig_if  = if_req  && !((state_q == S_RESP) && (win_q == P_IF));
      elig_d   = d_req   && !((state_q == S_RESP) && (win_q == P_D));
      elig_dbg = dbg_req && !((state_q == S_RESP) && (win_q == P_DBG));
      forced   = elig_if && (wait_q == WAIT_MAX);
      grant    = P_NONE;
      if (arb_en) begin
         if (forced)        grant = P_IF;
         else if (elig_dbg) grant = P_DBG;
         else if (elig_d)   grant = P_D;
         else if (elig_if)  grant = P_IF;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         win_q        <= P_NONE;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         lat_q        <= '0;
         wait_q       <= '0;
         mem_en_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         if_rdata_q   <= '0;
         d_rdata_q    <= '0;
         dbg_rdata_q  <= '0;
         if_rvalid_q  <= 1'b0;
         d_rvalid_q   <= 1'b0;
         dbg_rvalid_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         win_q        <= win_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         lat_q        <= lat_d;
         wait_q       <= wait_d;
         mem_en_q     <= mem_en_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         if_rdata_q   <= if_rdata_d;
         d_rdata_q    <= d_rdata_d;
         dbg_rdata_q  <= dbg_rdata_d;
         if_rvalid_q  <= if_rvalid_d;
         d_rvalid_q   <= d_rvalid_d;
         dbg_rvalid_q <= dbg_rvalid_d;
         busy_q       <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      lat_d   = lat_q;
      wait_d  = wait_q;
      case (state_q)
         S_IDLE, S_RESP: begin
            state_d = S_IDLE;
            if (grant != P_NONE) begin
               state_d = S_ACCESS;
               win_d   = grant;
               case (grant)
                  P_IF: begin
                     we_d    = 1'b0;
                     addr_d  = if_addr;
                     wdata_d = '0;
                  end
                  P_D: begin
                     we_d    = d_we;
                     addr_d  = d_addr;
                     wdata_d = d_wdata;
                  end
                  default: begin
                     we_d    = dbg_we;
                     addr_d  = dbg_addr;
                     wdata_d = dbg_wdata;
                  end
               endcase
               if (grant == P_IF)                     wait_d = '0;
               else if (elig_if && wait_q < WAIT_MAX) wait_d = wait_q + 4'd1;
            end
         end
         S_ACCESS: begin
            lat_d   = LAT_LOAD;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (lat_q == '0) state_d = S_RESP;
            else             lat_d   = lat_q - 4'd1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are registered, so they are computed from the upcoming state.
   always_comb begin
      capture      = (state_q == S_WAIT) && (lat_q == '0) && !we_q;
      mem_en_d     = (state_d == S_ACCESS);
      mem_we_d     = mem_en_d && we_d;
      mem_addr_d   = mem_en_d ? addr_d  : '0;
      mem_wdata_d  = mem_en_d ? wdata_d : '0;
      busy_d       = (state_d != S_IDLE);
      if_rvalid_d  = (state_d == S_RESP) && (win_d == P_IF);
      d_rvalid_d   = (state_d == S_RESP) && (win_d == P_D);
      dbg_rvalid_d = (state_d == S_RESP) && (win_d == P_DBG);
      if_rdata_d   = (capture && win_q == P_IF)  ? mem_rdata : if_rdata_q;
      d_rdata_d    = (capture && win_q == P_D)   ? mem_rdata : d_rdata_q;
      dbg_rdata_d  = (capture && win_q == P_DBG) ? mem_rdata : dbg_rdata_q;
   end

   assign mem_en     = mem_en_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign if_rdata   = if_rdata_q;
   assign d_rdata    = d_rdata_q;
   assign dbg_rdata  = dbg_rdata_q;
   assign if_rvalid  = if_rvalid_q;
   assign d_rvalid   = d_rvalid_q;
   assign dbg_rvalid = dbg_rvalid_q;
   assign busy       = busy_q;
   assign pipe_stall = (if_req & ~if_rvalid_q) | (d_req & ~d_rvalid_q) | dbg_req;

endmodule
